regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the single register-file write port among NREQ writeback requesters (ALU, load unit, link/jal) using a valid/ready handshake and round-robin arbitration. It registers the winning write and drives the register file's `regwrite`/`jal_ra`/`wr_in`/`write_data_in` for exactly one cycle per accepted request. The block sits between the execute/memory writeback sources and the register file, and optionally forwards its pending write onto the two read ports.

## Interface
- `W`, 32: data width.
- `NREQ`, 3: number of requesters (2..8).
- `clock` in 1: sole clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `hold` in 1: when high, no new grants are issued.
- `req_valid` in NREQ: request valid, one bit per requester.
- `req_ready` out NREQ: grant/accept, one-hot or zero.
- `req_link` in NREQ: request is a link write; target forced to r31.
- `req_addr` in NREQ*5: destination register, requester i at [5i+4:5i].
- `req_data` in NREQ*W: write data, requester i at [W*i+W-1:W*i].
- `regwrite` out 1: register-file write enable.
- `jal_ra` out 1: link write to r31.
- `wr_in` out 5: write address (31 when `jal_ra`).
- `write_data_in` out W: write data.
- `conflict_cnt` out 16: saturating count of cycles with more than one request pending.
- `rr1_in`, `rr2_in` in 5: read addresses also presented to the register file.
- `rdata1_in`, `rdata2_in` in W: register-file read data.
- `fwd1_out`, `fwd2_out` out W: read data after optional forwarding.

## Operation
- Requester i is accepted on a posedge when `req_valid[i] && req_ready[i]`.
- `req_ready` is combinational from `req_valid`, `hold`, and the round-robin pointer. It is all-zero when `hold` is high or no request is valid.
- Round-robin search starts at `last+1` mod NREQ. On each acceptance `last` becomes the granted index. After reset `last = NREQ-1`, so requester 0 has first priority.
- Acceptance loads the output register:
  - `jal_ra = req_link[i]`
  - `wr_in = req_link[i] ? 31 : req_addr[i]`
  - `write_data_in = req_data[i]`
  - `regwrite = req_link[i] || req_addr[i] != 0`
- A non-link write to r0 is consumed: it is acknowledged and `last` advances, but `regwrite` stays 0.
- With no acceptance on a posedge, `regwrite` and `jal_ra` clear to 0. `wr_in` and `write_data_in` hold their last values.
- `hold` never cancels a write already in the output register.
- Requesters keep `req_valid`, `req_addr`, `req_data` and `req_link` stable until accepted.
- `conflict_cnt` increments on each posedge where `popcount(req_valid) > 1` and `hold` is low. It saturates at 16'hFFFF.
- Reset (asserted at any time, including while a write is pending) immediately clears everything:
  - `regwrite`, `jal_ra`, `wr_in`, `write_data_in` and `conflict_cnt` go to 0.
  - `last` goes to NREQ-1.
  - `req_ready` is forced to 0 while reset is low.
  - A pending write is dropped.

## Timing
- Latency is 1 cycle: a request accepted at posedge N drives `regwrite` during cycle N..N+1. The register file captures it at the negedge inside that cycle.
- Throughput is one write per cycle. Back-to-back grants to different requesters are legal.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once per NREQ cycles.
- `fwd*_out` and `req_ready` are purely combinational. There is no path from `req_valid` to `regwrite` within a cycle.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined:
  - `fwdK_out = write_data_in` when `regwrite && rrK_in == wr_in && wr_in != 0`.
  - Otherwise `fwdK_out = rdataK_in`.
  - This covers the first half-cycle, before the negedge write lands.
- Not defined: `fwdK_out = rdataK_in` unconditionally. The `rr*_in` inputs are unused.

## Structure
- Shared package `regfile_pkg` holds:
  - `REG_ZERO = 5'd0`, `REG_RA = 5'd31`.
  - Requester index constants `REQ_ALU = 0`, `REQ_LOAD = 1`, `REQ_LINK = 2`.
  - A `wb_req_t` typedef {link, addr[4:0], data[W-1:0]}.
- One sub-module: `rr_arbiter` (parameter NREQ), with inputs req, hold, last and output one-hot grant. Pointer update stays in the top.

## Test plan
- Reset release, req_valid=3'b001, addr=5, data=32'hDEAD → `req_ready=001`; next cycle `regwrite=1`, `wr_in=5`, `write_data_in=32'hDEAD`; the cycle after, `regwrite=0`.
- All three requesters valid for 6 cycles → grant order 0,1,2,0,1,2; `conflict_cnt=6`; each grant is followed by a one-cycle write.
- req_link=1 with addr=7, data=32'h40 → `jal_ra=1`, `wr_in=31`, `regwrite=1`. Non-link write to addr 0 → accepted, `regwrite=0`.
- `hold=1` with requests pending → `req_ready=0` and no writes. Assert reset low mid-write → all outputs 0 asynchronously, and requester 0 is granted first after release.
- With `REGFILE_WB_BYPASS_EN`: pending write r9=32'h1234, rr1_in=9, rdata1_in=0 → `fwd1_out=32'h1234`. With rr1_in=0 and a write targeting r0 → `fwd1_out=rdata1_in`. Without the macro → `fwd1_out=rdata1_in` always.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file writeback path.
//   REG_ZERO / REG_RA : hardwired-zero register and link register indices.
//   REQ_*             : fixed requester slot assignment on the writeback arbiter.
//   wb_req_t          : one writeback request {link, addr, data} at the default
//                       32-bit datapath width.
package regfile_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_LINK = 2;

    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic                 link;
        logic [4:0]           addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant.
//   req   [NREQ]     : pending request bits
//   hold             : suppresses every grant
//   last  [LW]       : index granted most recently; search starts at last+1
//   grant [NREQ]     : one-hot grant, or zero
module rr_arbiter #(
    parameter int NREQ = 3,
    localparam int LW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            hold,
    input  logic [LW-1:0]   last,
    output logic [NREQ-1:0] grant
);

    logic          found;
    logic [LW-1:0] idx;

    // Walk the ring once, starting just after the previous winner.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        if (!hold) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = LW'((int'(last) + k) % NREQ);
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among NREQ writeback
// sources with valid/ready handshake and round-robin arbitration. The winner is
// registered and drives regwrite/jal_ra/wr_in/write_data_in for one cycle.
//   clock, reset (async, active low)
//   hold                        : block new grants
//   req_valid/ready/link [NREQ] : per-requester handshake and link flag
//   req_addr [NREQ*5], req_data [NREQ*W] : packed per-requester fields
//   regwrite, jal_ra, wr_in, write_data_in : registered write to the regfile
//   conflict_cnt                : saturating count of contended cycles
//   rr1_in/rr2_in, rdata1_in/rdata2_in -> fwd1_out/fwd2_out : read ports
// Optional feature: define REGFILE_WB_BYPASS_EN to forward the registered write
// onto the read ports before the register file captures it at the negedge.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int W    = 32,
    parameter int NREQ = 3,
    localparam int LW  = $clog2(NREQ)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_link,
    input  logic [NREQ*5-1:0] req_addr,
    input  logic [NREQ*W-1:0] req_data,
    output logic              regwrite,
    output logic              jal_ra,
    output logic [4:0]        wr_in,
    output logic [W-1:0]      write_data_in,
    output logic [15:0]       conflict_cnt,
    input  logic [4:0]        rr1_in,
    input  logic [4:0]        rr2_in,
    input  logic [W-1:0]      rdata1_in,
    input  logic [W-1:0]      rdata2_in,
    output logic [W-1:0]      fwd1_out,
    output logic [W-1:0]      fwd2_out
);

    logic [NREQ-1:0][4:0]   addr_a;
    logic [NREQ-1:0][W-1:0] data_a;
    logic [NREQ-1:0]        grant;
    logic [LW-1:0]          last;
    logic [LW-1:0]          gidx;
    logic                   accept;
    logic                   sel_link;
    logic [4:0]             sel_addr;

    assign addr_a = req_addr;
    assign data_a = req_data;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .hold  (hold),
        .last  (last),
        .grant (grant)
    );

    // Grant is only ever raised on a valid bit, so any grant is an acceptance.
    assign req_ready = reset ? grant : '0;
    assign accept    = |req_ready;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) gidx = LW'(i);
    end

    assign sel_link = req_link[gidx];
    assign sel_addr = addr_a[gidx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regwrite      <= 1'b0;
            jal_ra        <= 1'b0;
            wr_in         <= REG_ZERO;
            write_data_in <= '0;
            conflict_cnt  <= '0;
            last          <= LW'(NREQ - 1);
        end else begin
            if (accept) begin
                // A plain write to r0 is acknowledged but never reaches the file.
                regwrite      <= sel_link || (sel_addr != REG_ZERO);
                jal_ra        <= sel_link;
                wr_in         <= sel_link ? REG_RA : sel_addr;
                write_data_in <= data_a[gidx];
                last          <= gidx;
            end else begin
                regwrite <= 1'b0;
                jal_ra   <= 1'b0;
            end
            if (!hold && ($countones(req_valid) > 1) && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Read data for the register being written this cycle is still stale until
    // the negedge; substitute the in-flight value.
    assign fwd1_out = (regwrite && rr1_in == wr_in && wr_in != REG_ZERO) ? write_data_in : rdata1_in;
    assign fwd2_out = (regwrite && rr2_in == wr_in && wr_in != REG_ZERO) ? write_data_in : rdata2_in;
`else
    logic unused_rr;
    assign unused_rr = ^{rr1_in, rr2_in};
    assign fwd1_out  = rdata1_in;
    assign fwd2_out  = rdata2_in;
`endif

endmodule
